// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with a valid/ready request port and a registered,
// valid/ready result port. Single-cycle ops complete on the accept edge, so
// they can stream at one per clock. Divide (B != 0) runs an iterative
// restoring divider on operand magnitudes, then fixes the signs.
//
// Ports
//   CLK          clock, rising edge
//   RST          asynchronous active-low reset
//   A, B         operands (OPER_WIDTH)
//   ALU_FUN      opcode (4 bits)
//   SIGNED_MODE  1 = operands are two's complement
//   IN_VALID     request valid
//   IN_READY     request accepted this cycle when IN_VALID is also 1
//   ALU_OUT      registered result (OUT_WIDTH)
//   OUT_VALID    ALU_OUT holds a result
//   OUT_READY    consumer takes the result
//   DIV_BY_ZERO  registered flag for the current result
module alu_seq #(
  parameter int OPER_WIDTH = 8,
  parameter int OUT_WIDTH  = 2 * OPER_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [OPER_WIDTH-1:0] A,
  input  logic [OPER_WIDTH-1:0] B,
  input  logic [3:0]            ALU_FUN,
  input  logic                  SIGNED_MODE,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  output logic [OUT_WIDTH-1:0]  ALU_OUT,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic                  DIV_BY_ZERO
);

  localparam int W  = OPER_WIDTH;
  localparam int CW = $clog2(OPER_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Zero- or sign-extend an operand to the result width.
  function automatic logic [OUT_WIDTH-1:0] extend(input logic [W-1:0] v, input logic sgn);
    logic [OUT_WIDTH-1:0] r;
    r        = {OUT_WIDTH{sgn & v[W-1]}};
    r[W-1:0] = v;
    return r;
  endfunction

  // Two's-complement negate when neg is set.
  function automatic logic [W-1:0] cond_neg(input logic [W-1:0] v, input logic neg);
    logic [W-1:0] r;
    if (neg) begin
      r = ~v + {{(W-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction

  state_t               state_q, state_d;
  logic [OUT_WIDTH-1:0] alu_out_q, alu_out_d;
  logic                 out_valid_q, out_valid_d;
  logic                 dbz_q, dbz_d;
  // Divider: rem_q partial remainder, quo_q shifts dividend out / quotient in.
  logic [W-1:0]         rem_q, rem_d;
  logic [W-1:0]         quo_q, quo_d;
  logic [W-1:0]         dvs_q, dvs_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 negq_q, negq_d;
  logic                 negr_q, negr_d;

  logic [OUT_WIDTH-1:0] a_ext_s, b_ext_s, single_res_s;
  logic                 in_ready_s, accept_s, is_div_s, b_zero_s, start_div_s;
  logic [W:0]           shifted_s;
  logic                 fits_s;

  assign in_ready_s  = (state_q == IDLE) || ((state_q == DONE) && OUT_READY);
  assign accept_s    = IN_VALID & in_ready_s;
  assign is_div_s    = (ALU_FUN == 4'h3);
  assign b_zero_s    = (B == {W{1'b0}});
  assign start_div_s = accept_s & is_div_s & ~b_zero_s;

  assign a_ext_s = extend(A, SIGNED_MODE);
  assign b_ext_s = extend(B, SIGNED_MODE);

  // One restoring step: bring in the next dividend bit and try to subtract.
  assign shifted_s = {rem_q, quo_q[W-1]};
  assign fits_s    = (shifted_s >= {1'b0, dvs_q});

  // Result of every op that completes on the accept edge.
  always_comb begin
    single_res_s = {OUT_WIDTH{1'b0}};
    case (ALU_FUN)
      4'h0: single_res_s = a_ext_s + b_ext_s;
      4'h1: single_res_s = a_ext_s - b_ext_s;
      4'h2: single_res_s = a_ext_s * b_ext_s;
      // Only reached with B == 0: quotient all-ones, remainder A.
      4'h3: single_res_s = OUT_WIDTH'({A, {W{1'b1}}});
      4'h4: single_res_s = extend(A & B, 1'b0);
      4'h5: single_res_s = extend(A | B, 1'b0);
      4'h6: single_res_s = extend(~(A & B), 1'b0);
      4'h7: single_res_s = extend(~(A | B), 1'b0);
      4'h8: single_res_s = extend(A ^ B, 1'b0);
      4'h9: single_res_s = extend(~(A ^ B), 1'b0);
      4'hA: single_res_s = (A == B) ? OUT_WIDTH'(2'd1) : {OUT_WIDTH{1'b0}};
      // Extended operands compare correctly as signed in both modes.
      4'hB: single_res_s = ($signed(a_ext_s) > $signed(b_ext_s)) ? OUT_WIDTH'(2'd2) : {OUT_WIDTH{1'b0}};
      4'hC: single_res_s = ($signed(a_ext_s) < $signed(b_ext_s)) ? OUT_WIDTH'(2'd3) : {OUT_WIDTH{1'b0}};
      4'hD: single_res_s = {a_ext_s[OUT_WIDTH-1] & SIGNED_MODE, a_ext_s[OUT_WIDTH-1:1]};
      4'hE: single_res_s = {a_ext_s[OUT_WIDTH-2:0], 1'b0};
      default: single_res_s = {OUT_WIDTH{1'b0}};
    endcase
  end

  // Next-state, result and divider update.
  always_comb begin
    state_d     = state_q;
    alu_out_d   = alu_out_q;
    out_valid_d = out_valid_q;
    dbz_d       = dbz_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    negq_d      = negq_q;
    negr_d      = negr_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept_s) begin
          if (start_div_s) begin
            state_d     = DIV;
            out_valid_d = 1'b0;
            rem_d       = {W{1'b0}};
            quo_d       = cond_neg(A, SIGNED_MODE & A[W-1]);
            dvs_d       = cond_neg(B, SIGNED_MODE & B[W-1]);
            cnt_d       = {CW{1'b0}};
            negq_d      = SIGNED_MODE & (A[W-1] ^ B[W-1]);
            negr_d      = SIGNED_MODE & A[W-1];
          end else begin
            state_d     = DONE;
            alu_out_d   = single_res_s;
            out_valid_d = 1'b1;
            dbz_d       = is_div_s;
          end
        end else if ((state_q == DONE) && OUT_READY) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      DIV: begin
        // W iteration steps, then one edge to apply signs and publish.
        if (cnt_q == CW'(W)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          dbz_d       = 1'b0;
          alu_out_d   = OUT_WIDTH'({cond_neg(rem_q, negr_q), cond_neg(quo_q, negq_q)});
        end else begin
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
          if (fits_s) begin
            rem_d = shifted_s[W-1:0] - dvs_q;
            quo_d = {quo_q[W-2:0], 1'b1};
          end else begin
            rem_d = shifted_s[W-1:0];
            quo_d = {quo_q[W-2:0], 1'b0};
          end
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State, result and divider registers with asynchronous reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      alu_out_q   <= {OUT_WIDTH{1'b0}};
      out_valid_q <= 1'b0;
      dbz_q       <= 1'b0;
      rem_q       <= {W{1'b0}};
      quo_q       <= {W{1'b0}};
      dvs_q       <= {W{1'b0}};
      cnt_q       <= {CW{1'b0}};
      negq_q      <= 1'b0;
      negr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_out_q   <= alu_out_d;
      out_valid_q <= out_valid_d;
      dbz_q       <= dbz_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      negq_q      <= negq_d;
      negr_q      <= negr_d;
    end
  end

  assign IN_READY    = in_ready_s;
  assign ALU_OUT     = alu_out_q;
  assign OUT_VALID   = out_valid_q;
  assign DIV_BY_ZERO = dbz_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (OPER_WIDTH=8, OUT_WIDTH=16).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_alu_seq;

  logic        CLK;
  logic        RST;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [3:0]  ALU_FUN;
  logic        SIGNED_MODE;
  logic        IN_VALID;
  logic        IN_READY;
  logic [15:0] ALU_OUT;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic        DIV_BY_ZERO;

  int total = 0;
  int bad   = 0;

  alu_seq #(.OPER_WIDTH(8), .OUT_WIDTH(16)) dut (
    .CLK(CLK), .RST(RST), .A(A), .B(B), .ALU_FUN(ALU_FUN),
    .SIGNED_MODE(SIGNED_MODE), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .ALU_OUT(ALU_OUT), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .DIV_BY_ZERO(DIV_BY_ZERO)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op, input logic sm);
    A           = a;
    B           = b;
    ALU_FUN     = op;
    SIGNED_MODE = sm;
    IN_VALID    = 1'b1;
  endtask

  // Single-cycle op: accepted on the next edge, result visible right after.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] op, input logic sm, input logic [15:0] exp);
    drive(a, b, op, sm);
    tick();
    chk(tag, {16'h0, ALU_OUT}, {16'h0, exp});
    chk({tag, "_valid"}, {31'h0, OUT_VALID}, 32'd1);
  endtask

  // Divide: count edges from the accept edge until OUT_VALID rises.
  task automatic div_case(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic sm, input logic [15:0] exp);
    int n;
    drive(a, b, 4'h3, sm);
    tick();
    chk({tag, "_busy_rdy"}, {31'h0, IN_READY}, 32'd0);
    chk({tag, "_busy_vld"}, {31'h0, OUT_VALID}, 32'd0);
    // Junk request held during DIV must not be taken.
    drive(8'h01, 8'h01, 4'h0, 1'b0);
    n = 0;
    do begin
      tick();
      n++;
    end while (!OUT_VALID && n < 30);
    IN_VALID = 1'b0;
    chk({tag, "_latency"}, n, 32'd9);
    chk(tag, {16'h0, ALU_OUT}, {16'h0, exp});
    chk({tag, "_dbz"}, {31'h0, DIV_BY_ZERO}, 32'd0);
    tick();
  endtask

  initial begin
    RST         = 1'b0;
    A           = 8'h00;
    B           = 8'h00;
    ALU_FUN     = 4'h0;
    SIGNED_MODE = 1'b0;
    IN_VALID    = 1'b0;
    OUT_READY   = 1'b1;
    repeat (3) tick();
    chk("rst_out", {16'h0, ALU_OUT}, 32'h0);
    chk("rst_valid", {31'h0, OUT_VALID}, 32'd0);
    chk("rst_dbz", {31'h0, DIV_BY_ZERO}, 32'd0);
    RST = 1'b1;
    tick();
    chk("rst_rel_ready", {31'h0, IN_READY}, 32'd1);

    // Unsigned add, then drain to IDLE.
    run_op("add_u", 8'd200, 8'd100, 4'h0, 1'b0, 16'h012C);
    IN_VALID = 1'b0;
    tick();
    chk("add_drain_valid", {31'h0, OUT_VALID}, 32'd0);

    run_op("mul_s", 8'hFD, 8'h05, 4'h2, 1'b1, 16'hFFF1);
    IN_VALID = 1'b0;
    tick();

    div_case("div_u", 8'd200, 8'd7, 1'b0, 16'h041C);
    div_case("div_s", 8'hF9, 8'h02, 1'b1, 16'hFFFD);

    // Divide by zero, immediately followed by an add.
    drive(8'h55, 8'h00, 4'h3, 1'b0);
    tick();
    chk("dbz_out", {16'h0, ALU_OUT}, 32'h55FF);
    chk("dbz_flag", {31'h0, DIV_BY_ZERO}, 32'd1);
    chk("dbz_valid", {31'h0, OUT_VALID}, 32'd1);
    run_op("dbz_next_add", 8'h01, 8'h02, 4'h0, 1'b0, 16'h0003);
    chk("dbz_cleared", {31'h0, DIV_BY_ZERO}, 32'd0);

    // Back-to-back single-cycle ops, one per clock.
    run_op("sub_u", 8'd5, 8'd10, 4'h1, 1'b0, 16'hFFFB);
    run_op("and", 8'hA5, 8'h3C, 4'h4, 1'b0, 16'h0024);
    run_op("or", 8'hA5, 8'h3C, 4'h5, 1'b0, 16'h00BD);
    run_op("nand", 8'hA5, 8'h3C, 4'h6, 1'b0, 16'h00DB);
    run_op("nor", 8'hA5, 8'h3C, 4'h7, 1'b0, 16'h0042);
    run_op("xor", 8'hA5, 8'h3C, 4'h8, 1'b0, 16'h0099);
    run_op("xnor", 8'hA5, 8'h3C, 4'h9, 1'b0, 16'h0066);
    run_op("eq", 8'h05, 8'h05, 4'hA, 1'b0, 16'h0001);
    run_op("gt_s", 8'h80, 8'h01, 4'hB, 1'b1, 16'h0000);
    run_op("gt_u", 8'h80, 8'h01, 4'hB, 1'b0, 16'h0002);
    run_op("lt_s", 8'h80, 8'h01, 4'hC, 1'b1, 16'h0003);
    run_op("shr_s", 8'h80, 8'h00, 4'hD, 1'b1, 16'hFFC0);
    run_op("shr_u", 8'h80, 8'h00, 4'hD, 1'b0, 16'h0040);
    run_op("shl_u", 8'h81, 8'h00, 4'hE, 1'b0, 16'h0102);
    run_op("zero", 8'hFF, 8'hFF, 4'hF, 1'b0, 16'h0000);
    IN_VALID = 1'b0;
    tick();

    // Backpressure: result must hold while the consumer stalls.
    OUT_READY = 1'b0;
    run_op("bp_first", 8'd10, 8'd20, 4'h0, 1'b0, 16'h001E);
    drive(8'd1, 8'd1, 4'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_out", {16'h0, ALU_OUT}, 32'h001E);
      chk("bp_hold_rdy", {31'h0, IN_READY}, 32'd0);
      chk("bp_hold_vld", {31'h0, OUT_VALID}, 32'd1);
    end
    OUT_READY = 1'b1;
    #1;
    chk("bp_release_rdy", {31'h0, IN_READY}, 32'd1);
    tick();
    chk("bp_next1", {16'h0, ALU_OUT}, 32'h0002);
    run_op("bp_next2", 8'd3, 8'd4, 4'h0, 1'b0, 16'h0007);
    IN_VALID = 1'b0;
    tick();

    // Reset in the middle of a division.
    drive(8'd200, 8'd7, 4'h3, 1'b0);
    tick();
    IN_VALID = 1'b0;
    repeat (3) tick();
    RST = 1'b0;
    #2;
    chk("rst_div_out", {16'h0, ALU_OUT}, 32'h0000);
    chk("rst_div_valid", {31'h0, OUT_VALID}, 32'd0);
    chk("rst_div_dbz", {31'h0, DIV_BY_ZERO}, 32'd0);
    RST = 1'b1;
    tick();
    chk("rst_div_ready", {31'h0, IN_READY}, 32'd1);
    chk("rst_div_idle_vld", {31'h0, OUT_VALID}, 32'd0);
    div_case("div_after_rst", 8'd100, 8'd10, 1'b0, 16'h000A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter OPER_WIDTH, default 8: operand width in bits, minimum 4.
REQ-002 SHALL have parameter OUT_WIDTH, default 2*OPER_WIDTH: result width.
REQ-003 SHALL have port CLK, input, 1: clock; all state updates on rising edge.
REQ-004 SHALL have port RST, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port A, input, OPER_WIDTH: operand A.
REQ-006 SHALL have port B, input, OPER_WIDTH: operand B.
REQ-007 SHALL have port ALU_FUN, input, 4: opcode.
REQ-008 SHALL have port SIGNED_MODE, input, 1: 1 = operands are two's complement.
REQ-009 SHALL have port IN_VALID, input, 1: A, B, ALU_FUN and SIGNED_MODE are valid.
REQ-010 SHALL have port IN_READY, output, 1: block accepts a request this cycle.
REQ-011 SHALL have port ALU_OUT, output, OUT_WIDTH: registered result.
REQ-012 SHALL have port OUT_VALID, output, 1: ALU_OUT is valid.
REQ-013 SHALL have port OUT_READY, input, 1: consumer takes the result.
REQ-014 SHALL have port DIV_BY_ZERO, output, 1: registered flag for the current result.

Function
REQ-015 SHALL accept a request on a rising edge where IN_VALID and IN_READY are both 1, capturing all inputs.
REQ-016 SHALL use the FSM states IDLE, DIV and DONE.
REQ-017 SHALL drive IN_READY = (state==IDLE) or (state==DONE and OUT_READY=1), making single-cycle ops back-to-back at one per clock.
REQ-018 SHALL, for a non-divide accept, load ALU_OUT, assert OUT_VALID on the next edge, and enter DONE.
REQ-019 SHALL use these opcodes: 0 add; 1 sub; 2 mul; 3 div; 4 and; 5 or; 6 nand; 7 nor; 8 xor; 9 xnor; A eq (result 1/0); B gt (result 2/0); C lt (result 3/0); D shift right by 1; E shift left by 1; F result 0.
REQ-020 SHALL zero-extend operands to OUT_WIDTH before arithmetic when SIGNED_MODE=0, and sign-extend them when SIGNED_MODE=1; results wrap modulo 2^OUT_WIDTH.
REQ-021 SHALL apply SIGNED_MODE to mul, div, gt, lt and shift right (arithmetic), and zero-extend logic-op results.
REQ-022 SHALL implement div (B!=0) as restoring division taking exactly OPER_WIDTH cycles in DIV, with OUT_VALID rising OPER_WIDTH+1 edges after accept.
REQ-023 SHALL format the div result as ALU_OUT = {remainder[OPER_WIDTH-1:0], quotient[OPER_WIDTH-1:0]}.
REQ-024 SHALL, for signed div, truncate the quotient toward zero and give the remainder the sign of A.
REQ-025 SHALL, for div with B==0, return quotient all-ones and remainder A with DIV_BY_ZERO=1, at single-cycle latency, bypassing DIV.
REQ-026 SHALL keep DIV_BY_ZERO at 0 for all other results.
REQ-027 SHALL hold ALU_OUT, DIV_BY_ZERO and OUT_VALID stable in DONE while OUT_READY=0.
REQ-028 SHALL, in DONE with OUT_READY=1, go to IDLE if no new accept occurs (OUT_VALID to 0), or load the new result or enter DIV if one does.
REQ-029 SHALL ignore IN_VALID while in DIV, since IN_READY=0 there.

Reset
REQ-030 SHALL, on RST low at any time including mid-division, force state IDLE, ALU_OUT=0, OUT_VALID=0, DIV_BY_ZERO=0 and clear the divider registers.
REQ-031 SHALL drive IN_READY=1 on the first edge after RST deasserts.

Verification
REQ-032 Reset check: assert RST during a div -> ALU_OUT=0x0000, OUT_VALID=0, IN_READY=1 after release.
REQ-033 Unsigned add: A=200, B=100, op 0 -> ALU_OUT=0x012C with OUT_VALID 1 cycle after accept.
REQ-034 Signed mul: A=0xFD (-3), B=5, SIGNED_MODE=1, op 2 -> ALU_OUT=0xFFF1.
REQ-035 Unsigned div: A=200, B=7, op 3 -> ALU_OUT=0x041C with OUT_VALID exactly 9 edges after accept; signed A=0xF9 (-7), B=2 -> 0xFFFD.
REQ-036 Div by zero: A=0x55, B=0, op 3 -> ALU_OUT=0x55FF and DIV_BY_ZERO=1 after 1 cycle; the next add clears the flag.
REQ-037 Backpressure: hold OUT_READY=0 for 5 cycles with IN_VALID=1 -> ALU_OUT stable and IN_READY=0; raising OUT_READY gives back-to-back results on consecutive cycles.
